// File: rtl/traffic_light_top.sv
// -----------------------------------------------------------------------------
// traffic_light_top
//   Programmable traffic-light controller with a small 4-bit register port.
//   The host programs red/green/yellow phase durations; while start is high
//   the lamps cycle RED -> GREEN -> YELLOW -> RED, each phase lasting its
//   programmed number of cycles (a programmed 0 means 16 cycles).
//
//   Register map (addr):
//     0 STATUS   read-only, {1'b0, yellow, green, red}
//     1 RED_T    R/W red phase duration
//     2 GREEN_T  R/W green phase duration
//     3 YELLOW_T R/W yellow phase duration
//
//   Optional feature, macro TLC_COUNT_READ_EN:
//     defined   - an addr-0 read returns the current phase counter (0 in IDLE)
//     undefined - an addr-0 read returns STATUS
//
// Ports
//   clk      in   1   rising-edge clock
//   reset_b  in   1   synchronous active-low reset
//   start    in   1   level enable for the light sequence
//   cs       in   1   register-port chip select
//   write    in   1   1 = write strobe (qualified by cs), 0 = read
//   addr     in   2   register address
//   wr_data  in   DW  write data
//   red      out  1   red lamp, registered
//   green    out  1   green lamp, registered
//   yellow   out  1   yellow lamp, registered
//   rd_data  out  DW  read data, registered, one cycle after the cs read edge
// -----------------------------------------------------------------------------
module traffic_light_top #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          start,
  input  logic          cs,
  input  logic          write,
  input  logic [1:0]    addr,
  input  logic [DW-1:0] wr_data,
  output logic          red,
  output logic          green,
  output logic          yellow,
  output logic [DW-1:0] rd_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RED    = 2'd1,
    S_GREEN  = 2'd2,
    S_YELLOW = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] red_t_q, red_t_d;
  logic [DW-1:0] green_t_q, green_t_d;
  logic [DW-1:0] yellow_t_q, yellow_t_d;
  logic          red_q, red_d;
  logic          green_q, green_d;
  logic          yellow_q, yellow_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic [DW-1:0] addr0_rd;

`ifdef TLC_COUNT_READ_EN
  // cnt_q is cleared whenever the FSM sits in IDLE, so this reads 0 there.
  assign addr0_rd = cnt_q;
`else
  assign addr0_rd = {1'b0, yellow_q, green_q, red_q};
`endif

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case/if structure below can leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    red_t_d    = red_t_q;
    green_t_d  = green_t_q;
    yellow_t_d = yellow_t_q;
    rd_data_d  = rd_data_q;

    // Phase sequencing. cnt holds the cycles remaining including the current
    // one; a loaded 0 wraps to 15 on the first decrement, giving 16 cycles.
    // Durations are loaded only on entry, so mid-phase writes wait a lap.
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RED;
          cnt_d   = red_t_q;
        end
      end
      default: begin
        if (!start) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DW'(1)) begin
          unique case (state_q)
            S_RED:    begin state_d = S_GREEN;  cnt_d = green_t_q;  end
            S_GREEN:  begin state_d = S_YELLOW; cnt_d = yellow_t_q; end
            default:  begin state_d = S_RED;    cnt_d = red_t_q;    end
          endcase
        end else begin
          cnt_d = cnt_q - DW'(1);
        end
      end
    endcase

    // Lamps are registered from the next state so they are one-hot to the
    // state the FSM occupies during the following cycle.
    red_d    = (state_d == S_RED);
    green_d  = (state_d == S_GREEN);
    yellow_d = (state_d == S_YELLOW);

    // Register port. Nothing is decoded unless cs is high, so X on
    // addr/wr_data/write while deselected cannot disturb any state.
    if (cs) begin
      if (write) begin
        unique case (addr)
          2'd1:    red_t_d    = wr_data;
          2'd2:    green_t_d  = wr_data;
          2'd3:    yellow_t_d = wr_data;
          default: ;
        endcase
      end else begin
        unique case (addr)
          2'd1:    rd_data_d = red_t_q;
          2'd2:    rd_data_d = green_t_q;
          2'd3:    rd_data_d = yellow_t_q;
          default: rd_data_d = addr0_rd;
        endcase
      end
    end else begin
      rd_data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the duration registers are reset along with everything else, so a
    // mid-sequence reset also forgets the programmed timing.
    if (!reset_b) begin
      // NOTE: non-blocking assignments keep every register updating from
      // pre-edge values regardless of statement order.
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      red_t_q    <= '0;
      green_t_q  <= '0;
      yellow_t_q <= '0;
      red_q      <= 1'b0;
      green_q    <= 1'b0;
      yellow_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      red_t_q    <= red_t_d;
      green_t_q  <= green_t_d;
      yellow_t_q <= yellow_t_d;
      red_q      <= red_d;
      green_q    <= green_d;
      yellow_q   <= yellow_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign red     = red_q;
  assign green   = green_q;
  assign yellow  = yellow_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_traffic_light_top.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_top
//   Directed and randomized stimulus for traffic_light_top. A behavioural model
//   tracks the phase as (phase number, phase length, cycles elapsed) and the
//   register file as an int array; every cycle the lamps and rd_data are
//   compared with it. A few directed phase-length measurements are added.
// -----------------------------------------------------------------------------
module tb_traffic_light_top;

  logic       clk = 1'b0;
  logic       reset_b;
  logic       start;
  logic       cs;
  logic       write;
  logic [1:0] addr;
  logic [3:0] wr_data;
  logic       red, green, yellow;
  logic [3:0] rd_data;

  int checks = 0;
  int errors = 0;

  // Model state: phase 0 idle, 1 red, 2 green, 3 yellow.
  int         m_phase, m_len, m_el;
  int         m_dur [1:3];
  logic [3:0] m_rd;

  traffic_light_top dut (
    .clk     (clk),
    .reset_b (reset_b),
    .start   (start),
    .cs      (cs),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .red     (red),
    .green   (green),
    .yellow  (yellow),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  function automatic int plen(int d);
    return (d == 0) ? 16 : d;
  endfunction

  function automatic logic [2:0] lamps(int ph);
    case (ph)
      1:       return 3'b001;
      2:       return 3'b010;
      3:       return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model of one clock edge, using the inputs as driven before the edge.
  task automatic model_edge();
    int         pre_dur [1:3];
    logic [2:0] pre_l;
    int         nxt;
    if (!reset_b) begin
      m_phase = 0; m_len = 0; m_el = 0; m_rd = '0;
      for (int i = 1; i <= 3; i++) m_dur[i] = 0;
      return;
    end
    pre_dur = m_dur;
    pre_l   = lamps(m_phase);
    if (cs) begin
      if (write) begin
        if (addr != 2'd0) m_dur[int'(addr)] = int'(wr_data);
      end else if (addr == 2'd0) begin
`ifdef TLC_COUNT_READ_EN
        m_rd = (m_phase == 0) ? 4'd0 : 4'((m_len - m_el + 1) % 16);
`else
        m_rd = {1'b0, pre_l};
`endif
      end else begin
        m_rd = 4'(pre_dur[int'(addr)]);
      end
    end else begin
      m_rd = '0;
    end
    if (m_phase == 0) begin
      if (start) begin
        m_phase = 1; m_len = plen(pre_dur[1]); m_el = 1;
      end
    end else if (!start) begin
      m_phase = 0; m_len = 0; m_el = 0;
    end else if (m_el == m_len) begin
      nxt     = (m_phase == 3) ? 1 : m_phase + 1;
      m_phase = nxt; m_len = plen(pre_dur[nxt]); m_el = 1;
    end else begin
      m_el++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("lamps", {1'b0, yellow, green, red}, {1'b0, lamps(m_phase)});
    check("rd_data", rd_data, m_rd);
  endtask

  task automatic bus_idle();
    cs = 1'b0; write = 1'bx; addr = 2'bxx; wr_data = 4'bxxxx;
  endtask

  // cs one cycle early (a harmless read), then the write strobe.
  task automatic wr(input logic [1:0] a, input logic [3:0] d);
    cs = 1'b1; write = 1'b0; addr = a; wr_data = 4'bxxxx;
    step();
    write = 1'b1; wr_data = d;
    step();
    bus_idle();
  endtask

  task automatic rd(input logic [1:0] a);
    cs = 1'b1; write = 1'b0; addr = a; wr_data = 4'bxxxx;
    step();
    bus_idle();
  endtask

  function automatic logic lamp_sel(input int sel);
    logic [2:0] l;
    l = {yellow, green, red};
    return l[sel];
  endfunction

  task automatic wait_lamp(input int sel, input string tag);
    int k = 0;
    while (!lamp_sel(sel) && k < 60) begin
      step();
      k++;
    end
    check(tag, {3'b0, lamp_sel(sel)}, 4'd1);
  endtask

  // Counts consecutive cycles with the selected lamp on, starting now.
  task automatic count_lamp(input int sel, output int n);
    n = 0;
    while (lamp_sel(sel) && n < 40) begin
      n++;
      step();
    end
  endtask

  initial begin
    int n;
    int n2;
    int r;

    // 1. reset then idle reads
    reset_b = 1'b0; start = 1'b0; bus_idle();
    step();
    reset_b = 1'b1;
    step(); step();
    rd(2'd1); rd(2'd2); rd(2'd3); rd(2'd0);
    step();

    // 2. program durations and read them back
    wr(2'd1, 4'd5); wr(2'd2, 4'd10); wr(2'd3, 4'd15);
    wr(2'd0, 4'd9);
    rd(2'd1); rd(2'd2); rd(2'd3); rd(2'd0);

    // 3. run the sequence and measure each phase
    start = 1'b1;
    wait_lamp(0, "enter_red");
    count_lamp(0, n);  check("red_len",    4'(n), 4'd5);
    count_lamp(1, n);  check("green_len",  4'(n), 4'd10);
    count_lamp(2, n);  check("yellow_len", 4'(n), 4'd15);
    check("red_again", {3'b0, red}, 4'd1);

    // 4. reads while running
    rd(2'd1); rd(2'd2); rd(2'd3); rd(2'd0); rd(2'd0);
    step();

    // 5. drop start mid-GREEN, then restart with a full RED phase
    wait_lamp(1, "enter_green");
    step(); step(); step();
    start = 1'b0;
    step();
    check("stop_lamps", {1'b0, yellow, green, red}, 4'd0);
    step();
    start = 1'b1;
    wait_lamp(0, "restart_red");
    count_lamp(0, n);  check("restart_red_len", 4'(n), 4'd5);

    // 6. RED_T = 0 gives 16 cycles; a write during RED waits a lap
    start = 1'b0;
    step();
    wr(2'd1, 4'd0);
    start = 1'b1;
    wait_lamp(0, "red16_enter");
    wr(2'd1, 4'd2);
    count_lamp(0, n2);
    check("red16_len", 4'((n2 + 2) % 16), 4'd0);
    check("red16_len_hi", 4'((n2 + 2) / 16), 4'd1);
    wait_lamp(0, "red2_enter");
    count_lamp(0, n);  check("red2_len", 4'(n), 4'd2);

    // randomized traffic, including rare resets and start drops
    for (int i = 0; i < 600; i++) begin
      r       = $urandom_range(0, 199);
      reset_b = (r != 0);
      start   = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 2) == 0) begin
        cs      = 1'b1;
        write   = 1'($urandom_range(0, 1));
        addr    = 2'($urandom_range(0, 3));
        wr_data = 4'($urandom_range(0, 15));
      end else begin
        bus_idle();
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
